mtr_drv: RTL and testbench

//  Consumes the signed pitch-loop command (mtr_duty magnitude + rev sign) produced by
//  the duty block and drives one H-bridge motor. Generates a fixed-period PWM with

---
 rtl/mtr_drv_pkg.sv | 19 +
 rtl/mtr_drv_pwm_dt.sv | 68 ++++++
 rtl/mtr_drv.sv | 105 ++++++++++
 tb/tb_mtr_drv.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mtr_drv_pkg.sv
// Shared types and defaults for the H-bridge motor driver.
package mtr_drv_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_COAST = 2'd1,
        ST_FWD   = 2'd2,
        ST_REV   = 2'd3
    } state_t;

    localparam int unsigned CNT_W_DEF    = 12;
    localparam int unsigned DEADTIME_DEF = 32;

    // Bits needed to count 0..dt, never narrower than one bit.
    function automatic int unsigned dt_width(input int unsigned dt);
        return (dt < 1) ? 1 : $clog2(dt + 1);
    endfunction

endpackage

// File: rtl/mtr_drv_pwm_dt.sv
// One half-bridge leg: turns a raw PWM level into non-overlapping hi/lo gates
// separated by a dead time; pulses and gaps no longer than DEADTIME are swallowed.
module mtr_drv_pwm_dt
    import mtr_drv_pkg::*;
#(
    parameter int unsigned DEADTIME = DEADTIME_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm,
    input  logic hold,
    output logic hi,
    output logic lo
);

    localparam int unsigned       DT_W   = dt_width(DEADTIME);
    localparam logic [DT_W-1:0]   DT_MAX = DT_W'(DEADTIME);

    logic [DT_W-1:0] run_q, run_d;
    logic            lvl_q, lvl_d;
    logic            act_q;
    logic            hi_q, hi_d;
    logic            lo_q, lo_d;

    // pwm is the level for the cycle these registers will be visible in, so a
    // change drops the opposite gate in that same cycle. A leg coming out of
    // hold treats its first level as fresh, so neither gate asserts until
    // DEADTIME cycles at that level have elapsed.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        lvl_d = pwm;
        run_d = run_q;
        if (!act_q || (pwm != lvl_q)) begin
            run_d = '0;
        end else if (run_q != DT_MAX) begin
            run_d = run_q + 1'b1;
        end
        hi_d =  lvl_d && (run_d == DT_MAX);
        lo_d = !lvl_d && (run_d == DT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            act_q <= 1'b0;
            lvl_q <= 1'b0;
            run_q <= '0;
            hi_q  <= 1'b0;
            lo_q  <= 1'b0;
        end else if (hold) begin
            act_q <= 1'b0;
            lvl_q <= 1'b0;
            run_q <= '0;
            hi_q  <= 1'b0;
            lo_q  <= 1'b0;
        end else begin
            act_q <= 1'b1;
            lvl_q <= lvl_d;
            run_q <= run_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/mtr_drv.sv
// H-bridge motor driver: fixed-period PWM, boundary-sampled duty/direction,
// coast period on reversal, dead-time protected switching leg.
module mtr_drv
    import mtr_drv_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned DEADTIME = DEADTIME_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] mtr_duty,
    input  logic             rev,
    output logic             a_hi,
    output logic             a_lo,
    output logic             b_hi,
    output logic             b_lo,
    output logic             prd_start
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             rev_q, rev_d;
    state_t           state_q, state_d;
    logic             boundary;
    logic             pwm_nxt;
    logic             prd_q;
    logic             a_lo_st_q, b_lo_st_q;
    logic             a_hi_sw, a_lo_sw, b_hi_sw, b_lo_sw;

    // Duty and direction are only taken at the period boundary; the legs see
    // the PWM level of the cycle they are about to drive.
    always_comb begin
        boundary = (cnt_q == CNT_MAX);
        cnt_d    = cnt_q + 1'b1;
        duty_d   = boundary ? mtr_duty : duty_q;
        rev_d    = boundary ? rev : rev_q;
        pwm_nxt  = (cnt_d < duty_d);

        state_d = state_q;
        if (!en) begin
            state_d = ST_OFF;
        end else if (boundary) begin
            case (state_q)
                ST_OFF:   state_d = ST_COAST;
                ST_COAST: state_d = rev_d ? ST_REV : ST_FWD;
                ST_FWD:   state_d = rev_d ? ST_COAST : ST_FWD;
                ST_REV:   state_d = rev_d ? ST_REV : ST_COAST;
                default:  state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            duty_q    <= '0;
            rev_q     <= 1'b0;
            state_q   <= ST_OFF;
            prd_q     <= 1'b0;
            a_lo_st_q <= 1'b0;
            b_lo_st_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            duty_q    <= duty_d;
            rev_q     <= rev_d;
            state_q   <= state_d;
            prd_q     <= (cnt_d == '0);
            a_lo_st_q <= (state_d == ST_REV);
            b_lo_st_q <= (state_d == ST_FWD);
        end
    end

    // Each leg is held off unless it is the switching leg of the next state.
    mtr_drv_pwm_dt #(
        .DEADTIME (DEADTIME)
    ) u_leg_a (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm   (pwm_nxt),
        .hold  (state_d != ST_FWD),
        .hi    (a_hi_sw),
        .lo    (a_lo_sw)
    );

    mtr_drv_pwm_dt #(
        .DEADTIME (DEADTIME)
    ) u_leg_b (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm   (pwm_nxt),
        .hold  (state_d != ST_REV),
        .hi    (b_hi_sw),
        .lo    (b_lo_sw)
    );

    assign a_hi      = a_hi_sw;
    assign a_lo      = a_lo_sw | a_lo_st_q;
    assign b_hi      = b_hi_sw;
    assign b_lo      = b_lo_sw | b_lo_st_q;
    assign prd_start = prd_q;

endmodule

// File: tb/tb_mtr_drv.sv
// Directed bench for mtr_drv: per-period gate counts, boundary sampling,
// reversal coast, edge duties, enable drop, async reset and non-overlap.
module tb_mtr_drv;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [11:0] mtr_duty;
    logic        rev;
    logic        a_hi, a_lo, b_hi, b_lo, prd_start;

    int n_checks;
    int n_fail;
    int n_overlap;

    mtr_drv #(
        .CNT_W    (12),
        .DEADTIME (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mtr_duty  (mtr_duty),
        .rev       (rev),
        .a_hi      (a_hi),
        .a_lo      (a_lo),
        .b_hi      (b_hi),
        .b_lo      (b_lo),
        .prd_start (prd_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((a_hi && a_lo) || (b_hi && b_lo)) n_overlap++;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Samples one full period starting at the current negedge (cnt==0).
    task automatic measure(input string tag, input int chg_at,
                           input logic [11:0] nd, input logic nr, input logic ne,
                           input logic sw_b,
                           input int e_ahi, input int e_alo, input int e_bhi, input int e_blo,
                           input int e_fhi, input int e_flo);
        int   c_ahi, c_alo, c_bhi, c_blo, f_hi, f_lo, n_prd;
        logic p0;
        c_ahi = 0; c_alo = 0; c_bhi = 0; c_blo = 0;
        f_hi = -1; f_lo = -1; n_prd = 0; p0 = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) p0 = prd_start;
            n_prd += int'(prd_start);
            c_ahi += int'(a_hi);
            c_alo += int'(a_lo);
            c_bhi += int'(b_hi);
            c_blo += int'(b_lo);
            if (sw_b) begin
                if (b_hi && f_hi < 0) f_hi = i;
                if (b_lo && f_lo < 0) f_lo = i;
            end else begin
                if (a_hi && f_hi < 0) f_hi = i;
                if (a_lo && f_lo < 0) f_lo = i;
            end
            if (i == chg_at) begin
                mtr_duty = nd;
                rev      = nr;
                en       = ne;
            end
        end
        check({tag, ".prd_at0"}, int'(p0), 1);
        check({tag, ".prd_cnt"}, n_prd, 1);
        check({tag, ".a_hi"}, c_ahi, e_ahi);
        check({tag, ".a_lo"}, c_alo, e_alo);
        check({tag, ".b_hi"}, c_bhi, e_bhi);
        check({tag, ".b_lo"}, c_blo, e_blo);
        check({tag, ".first_hi"}, f_hi, e_fhi);
        check({tag, ".first_lo"}, f_lo, e_flo);
    endtask

    initial begin
        int k_seen;
        int gates_on;
        int left;
        int n;

        n_checks = 0; n_fail = 0; n_overlap = 0;
        rst_n = 1'b0; en = 1'b0; rev = 1'b0; mtr_duty = 12'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({a_hi, a_lo, b_hi, b_lo, prd_start}), 0);
        rst_n = 1'b1;
        gates_on = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            gates_on += int'(|{a_hi, a_lo, b_hi, b_lo, prd_start});
        end
        check("off_after_release", gates_on, 0);

        // Forward at duty 1024: first boundary enters COAST
        en = 1'b1; rev = 1'b0; mtr_duty = 12'd1024;
        k_seen = 5000;
        for (int k = 1; k <= 5000; k++) begin
            @(negedge clk);
            if (prd_start) begin
                k_seen = k;
                break;
            end
        end
        check("first_prd_start", k_seen, 4091);

        measure("p1_coast", -1, 12'd1024, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, -1, -1);
        @(negedge clk);
        measure("p2_fwd1024", -1, 12'd1024, 1'b0, 1'b1, 1'b0, 992, 3040, 0, 4096, 32, 1056);

        // Duty change mid-period only applies from the next boundary
        @(negedge clk);
        measure("p3_fwd_chg", 500, 12'd3000, 1'b0, 1'b1, 1'b0, 992, 3040, 0, 4096, 32, 1056);
        @(negedge clk);
        measure("p4_fwd3000", -1, 12'd3000, 1'b0, 1'b1, 1'b0, 2968, 1064, 0, 4096, 32, 3032);

        // Reversal: finish FWD, coast one period, then REV
        @(negedge clk);
        measure("p5_fwd_rev", 1000, 12'd3000, 1'b1, 1'b1, 1'b0, 2968, 1064, 0, 4096, 32, 3032);
        @(negedge clk);
        measure("p6_coast", -1, 12'd3000, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, -1, -1);
        @(negedge clk);
        measure("p7_rev3000", 100, 12'd0, 1'b0, 1'b1, 1'b1, 0, 4096, 2968, 1064, 32, 3032);

        // Edge duties 0, 4095, 20
        @(negedge clk);
        measure("p8_coast", -1, 12'd0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, -1, -1);
        @(negedge clk);
        measure("p9_duty0", 100, 12'd4095, 1'b0, 1'b1, 1'b0, 0, 4064, 0, 4096, -1, 32);
        @(negedge clk);
        measure("p10_duty4095", 100, 12'd20, 1'b0, 1'b1, 1'b0, 4063, 0, 0, 4096, 32, -1);
        @(negedge clk);
        measure("p11_duty20", -1, 12'd20, 1'b0, 1'b1, 1'b0, 0, 4044, 0, 4096, -1, 52);

        // Enable drop mid-period: gates off from the next edge
        @(negedge clk);
        measure("p12_en_drop", 2000, 12'd20, 1'b0, 1'b0, 1'b0, 0, 1949, 0, 2001, -1, 52);

        en = 1'b1; rev = 1'b1; mtr_duty = 12'd2048;
        @(negedge clk);
        measure("p13_coast", -1, 12'd2048, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, -1, -1);
        @(negedge clk);
        measure("p14_rev2048", -1, 12'd2048, 1'b1, 1'b1, 1'b1, 0, 4096, 2016, 2016, 32, 2080);

        // Asynchronous reset while b_hi and a_lo are driven
        for (int i = 0; i <= 100; i++) @(negedge clk);
        check("pre_rst_b_hi", int'(b_hi), 1);
        check("pre_rst_a_lo", int'(a_lo), 1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_outputs", int'({a_hi, a_lo, b_hi, b_lo, prd_start}), 0);
        repeat (3) @(negedge clk);
        check("rst_held_outputs", int'({a_hi, a_lo, b_hi, b_lo, prd_start}), 0);
        rst_n = 1'b1;
        k_seen = 5000;
        gates_on = 0;
        for (int k = 1; k <= 5000; k++) begin
            @(negedge clk);
            gates_on += int'(|{a_hi, a_lo, b_hi, b_lo});
            if (prd_start) begin
                k_seen = k;
                break;
            end
        end
        check("rst_first_prd", k_seen, 4096);
        check("rst_off_gates", gates_on, 0);

        // Randomized duty/rev/en activity for the non-overlap invariant
        left = 12288;
        while (left > 0) begin
            n = $urandom_range(1, 1500);
            repeat (n) @(negedge clk);
            left -= n;
            en  = ($urandom_range(0, 7) != 0);
            rev = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       mtr_duty = 12'($urandom_range(0, 40));
                1:       mtr_duty = 12'(4095 - $urandom_range(0, 40));
                default: mtr_duty = 12'($urandom_range(0, 4095));
            endcase
        end
        check("no_overlap", n_overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
